// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: turns video timing into scaled framebuffer reads and RGB888 pixels.
// Optional macro FB_SCANOUT_TESTPATTERN_EN adds test_in, which selects vertical colour bars.
module framebuffer_scanout #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int SCALE_LOG2  = 2,
  parameter int FB_WIDTH    = 320,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        active_draw_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
`ifdef FB_SCANOUT_TESTPATTERN_EN
  input  logic        test_in,
`endif
  output logic [15:0] addr_out,
  output logic        read_en_out,
  input  logic [15:0] mem_data_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        frame_start_out
);

  localparam int          DEPTH   = 2 + MEM_LATENCY;
  localparam logic [10:0] H_END   = 11'(H_ACTIVE);
  localparam logic [9:0]  V_END   = 10'(V_ACTIVE);
  localparam logic [15:0] FB_STEP = 16'(FB_WIDTH);

  logic [15:0]      row_base;
  logic             frame_origin;
  logic             row_end;
  logic [15:0]      base_now;
  logic [15:0]      col;
  logic [DEPTH-1:0] hs_pipe;
  logic [DEPTH-1:0] vs_pipe;
  logic [DEPTH-1:0] act_pipe;
  logic [DEPTH-1:0] fs_pipe;
  logic [15:0]      pixel;

  always_comb begin
    frame_origin = (hcount_in == '0) && (vcount_in == '0);
    row_end      = (hcount_in == H_END) && (vcount_in < V_END) &&
                   (&vcount_in[SCALE_LOG2-1:0]);
    // The origin cycle already addresses from base 0, so a stale base never leaks out.
    base_now     = frame_origin ? '0 : row_base;
    col          = 16'(hcount_in >> SCALE_LOG2);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      row_base <= '0;
    end else if (frame_origin) begin
      row_base <= '0;
    end else if (row_end) begin
      row_base <= row_base + FB_STEP;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      addr_out    <= '0;
      read_en_out <= 1'b0;
    end else begin
      addr_out    <= base_now + col;
`ifdef FB_SCANOUT_TESTPATTERN_EN
      read_en_out <= active_draw_in & ~test_in;
`else
      read_en_out <= active_draw_in;
`endif
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hs_pipe  <= '0;
      vs_pipe  <= '0;
      act_pipe <= '0;
      fs_pipe  <= '0;
    end else begin
      hs_pipe  <= {hs_pipe[DEPTH-2:0], hsync_in};
      vs_pipe  <= {vs_pipe[DEPTH-2:0], vsync_in};
      act_pipe <= {act_pipe[DEPTH-2:0], active_draw_in};
      fs_pipe  <= {fs_pipe[DEPTH-2:0], frame_origin};
    end
  end

`ifdef FB_SCANOUT_TESTPATTERN_EN
  logic [2:0] bar_pipe [DEPTH-1];
  logic [2:0] bar;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) bar_pipe[i] <= '0;
    end else begin
      bar_pipe[0] <= hcount_in[10:8];
      for (int unsigned i = 1; i < DEPTH - 1; i++) bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  always_comb begin
    bar   = bar_pipe[DEPTH-2];
    pixel = mem_data_in;
    if (test_in) pixel = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
  end
`else
  always_comb pixel = mem_data_in;
`endif

  // Capture uses the stage before the output so colour and delayed syncs leave together.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (act_pipe[DEPTH-2]) begin
      red_out   <= {pixel[15:11], pixel[15:13]};
      green_out <= {pixel[10:5],  pixel[10:9]};
      blue_out  <= {pixel[4:0],   pixel[4:2]};
    end else begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end
  end

  always_comb begin
    hsync_out       = hs_pipe[DEPTH-1];
    vsync_out       = vs_pipe[DEPTH-1];
    active_draw_out = act_pipe[DEPTH-1];
    frame_start_out = fs_pipe[DEPTH-1];
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench for framebuffer_scanout: per-cycle reference model plus directed literal checks.
module tb_framebuffer_scanout;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] h;
  logic [9:0]  v;
  logic        act, hs, vs;
  logic [15:0] addr;
  logic        ren;
  logic [15:0] mdata;
  logic [7:0]  r, g, b;
  logic        hso, vso, acto, fso;
`ifdef FB_SCANOUT_TESTPATTERN_EN
  logic        test = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b1;
  bit override = 1'b0;

  always #5 clk = ~clk;

  framebuffer_scanout dut (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(h), .vcount_in(v),
    .active_draw_in(act), .hsync_in(hs), .vsync_in(vs),
`ifdef FB_SCANOUT_TESTPATTERN_EN
    .test_in(test),
`endif
    .addr_out(addr), .read_en_out(ren), .mem_data_in(mdata),
    .red_out(r), .green_out(g), .blue_out(b),
    .hsync_out(hso), .vsync_out(vso), .active_draw_out(acto), .frame_start_out(fso)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'd0) return 16'hF800;
    return (a * 16'h9E37) ^ (a >> 5) ^ 16'h1234;
  endfunction

  // Memory with two cycles of read latency
  logic [15:0] d1, d2;
  always @(posedge clk) begin
    d1 <= memf(addr);
    d2 <= d1;
  end
  assign mdata = override ? 16'hFFFF : d2;

  function automatic logic [23:0] expand(input logic [15:0] p);
    logic [4:0] r5; logic [5:0] g6; logic [4:0] b5;
    r5 = p[15:11]; g6 = p[10:5]; b5 = p[4:0];
    return {(8'(r5) << 3) | 8'(r5 >> 2), (8'(g6) << 2) | 8'(g6 >> 4), (8'(b5) << 3) | 8'(b5 >> 2)};
  endfunction

  // Reference model: one record per sampled input cycle
  typedef struct packed {
    logic [15:0] addr;
    logic        act, hs, vs, fs;
  } rec_t;

  rec_t hist [8];
  int   n = 0;
  int   rows = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      n = 0; rows = 0;
      for (int i = 0; i < 8; i++) hist[i] = '0;
    end else begin
      rec_t e;
      if (h == 0 && v == 0) rows = 0;
      e.addr = 16'((rows * 320 + int'(h) / 4) % 65536);
      e.act  = act; e.hs = hs; e.vs = vs;
      e.fs   = (h == 0 && v == 0);
      if (h == 1280 && v < 720 && (v % 4) == 3) rows++;
      hist[n % 8] = e;
      n++;
    end
  end

  function automatic rec_t get(input int k);
    if (n >= k) return hist[(n - k) % 8];
    return '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && model_on) begin
      rec_t a1, a4;
      logic [23:0] rgb;
      a1  = get(1);
      a4  = get(LAT);
      rgb = a4.act ? expand(memf(a4.addr)) : 24'd0;
      chk("model_addr", 32'(addr), 32'(a1.addr));
      chk("model_read_en", 32'(ren), 32'(a1.act));
      chk("model_hsync", 32'(hso), 32'(a4.hs));
      chk("model_vsync", 32'(vso), 32'(a4.vs));
      chk("model_active", 32'(acto), 32'(a4.act));
      chk("model_frame_start", 32'(fso), 32'(a4.fs));
      chk("model_rgb", 32'({r, g, b}), 32'(rgb));
    end
  end

  task automatic drive(input int hh, input int vv, input bit hsy = 1'b0,
                       input bit vsy = 1'b0, input bit force_act = 1'b0);
    @(negedge clk);
    h   = 11'(hh);
    v   = 10'(vv);
    act = force_act || (hh < 1280 && vv < 720);
    hs  = hsy;
    vs  = vsy;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 32'({addr, ren, r, g, b, hso, vso, acto, fso}), 32'd0);
  endtask

  logic [15:0] walk [8];
  int hh, vv;

  initial begin
    walk = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
    rst_n = 1'b1;
    h = 11'd1300; v = 10'd700; act = 1'b0; hs = 1'b0; vs = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Address walk and colour latency from (0,0)
    for (int k = 0; k < 8; k++) begin
      drive(k, 0);
      @(posedge clk); #1;
      chk("walk_addr", 32'(addr), 32'(walk[k]));
      if (k == 2) chk("frame_start_early", 32'(fso), 32'd0);
      if (k == 3) begin
        chk("origin_red", 32'(r), 32'hFF);
        chk("origin_green", 32'(g), 32'h00);
        chk("origin_blue", 32'(b), 32'h00);
        chk("origin_frame_start", 32'(fso), 32'd1);
      end
    end

    // Row advance and last address of a frame
    drive(0, 0);
    for (int rr = 0; rr < 179; rr++) begin
      drive(1280, 4 * rr + 3);
      if (rr == 0) begin
        drive(0, 4);
        @(posedge clk); #1;
        chk("row_advance_addr", 32'(addr), 32'd320);
      end
    end
    drive(1279, 719);
    @(posedge clk); #1;
    chk("last_addr", 32'(addr), 32'd57599);

    // Blanking with all-ones memory data
    repeat (6) drive(1300, 10);
    override = 1'b1;
    drive(1300, 10, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk("blank_read_en", 32'(ren), 32'd0);
      if (k == 2) chk("blank_hsync_early", 32'(hso), 32'd0);
      if (k == 3) begin
        chk("blank_hsync", 32'(hso), 32'd1);
        chk("blank_vsync", 32'(vso), 32'd1);
        chk("blank_rgb", 32'({r, g, b}), 32'd0);
      end
      drive(1300, 11);
    end
    repeat (6) drive(1300, 11);
    override = 1'b0;
    repeat (6) drive(1300, 11);

    // Randomized scan: sequential runs, jumps, mid-frame restarts, one mid-line reset
    hh = 0; vv = 0;
    for (int it = 0; it < 1500; it++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 75) begin
        hh++;
        if (hh >= 1400) begin hh = 0; vv++; if (vv >= 750) vv = 0; end
      end else if (sel < 92) begin
        hh = int'($urandom_range(0, 2047));
        vv = int'($urandom_range(0, 760));
        if ($urandom_range(0, 1) == 1) hh = 1280;
      end else begin
        hh = 0; vv = 0;
      end
      if (it == 700) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_all_zero("midline_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      drive(hh, vv, (hh >= 1300 && hh < 1340), (vv >= 725 && vv < 728));
    end

`ifdef FB_SCANOUT_TESTPATTERN_EN
    model_on = 1'b0;
    test = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1792, 5, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      if (k == 0) chk("test_read_en", 32'(ren), 32'd0);
      if (k == 3) chk("test_bar7_rgb", 32'({r, g, b}), 32'hFFFFFF);
    end
    test = 1'b0;
`endif

    repeat (6) drive(1300, 11);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
